// File: rtl/universal_reg_pkg.sv
// rtl/universal_reg_pkg.sv - shared mode encodings and width limits for universal_reg
package universal_reg_pkg;

  // Mode select encodings
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_CUP  = 3'b110;
  localparam logic [2:0] M_CDN  = 3'b111;

  // Supported register widths
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // True when a requested width lies in the supported range
  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/dff_cell.sv
// rtl/dff_cell.sv - one-bit edge-triggered flop with sync reset, enable and complement output
module dff_cell (
  input  logic c,
  input  logic rst,
  input  logic en,
  input  logic rv,
  input  logic d,
  output logic q,
  output logic qp
);

  // Reset wins over enable; disabled cell keeps its value
  always_ff @(posedge c) begin
    if (rst) begin
      q <= rv;
    end else if (en) begin
      q <= d;
    end
  end

  // Complement is derived from the stored bit, never stored separately
  assign qp = ~q;

endmodule

// File: rtl/universal_reg.sv
// rtl/universal_reg.sv - WIDTH-bit hold/load/shift/rotate/count register
module universal_reg
  import universal_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       m,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qp,
  output logic             so,
  output logic             tc
);

  localparam bit WIDTH_OK = width_legal(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  generate
    if (!WIDTH_OK) begin : g_bad_width
      $error("universal_reg: WIDTH out of supported range");
    end
  endgenerate

  logic [WIDTH-1:0] nxt;

  // Per-bit next-state selection; enable and reset are applied in the cells
  always_comb begin
    nxt = q;
    case (m)
      M_HOLD:  nxt = q;
      M_LOAD:  nxt = d;
      M_SHR:   nxt = {si, q[WIDTH-1:1]};
      M_SHL:   nxt = {q[WIDTH-2:0], si};
      M_ROR:   nxt = {q[0], q[WIDTH-1:1]};
      M_ROL:   nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      M_CUP:   nxt = q + ONE;
      M_CDN:   nxt = q - ONE;
      default: nxt = q;
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      dff_cell u_cell (
        .c  (c),
        .rst(rst),
        .en (en),
        .rv (RESET_VAL[i]),
        .d  (nxt[i]),
        .q  (q[i]),
        .qp (qp[i])
      );
    end
  endgenerate

  // Serial-out shows the bit that the selected shift/rotate would push out
  always_comb begin
    so = 1'b0;
    case (m)
      M_SHR, M_ROR: so = q[0];
      M_SHL, M_ROL: so = q[WIDTH-1];
      default:      so = 1'b0;
    endcase
  end

  // Terminal count ignores en so cascaded stages can gate on en & tc
  always_comb begin
    tc = 1'b0;
    case (m)
      M_CUP:   tc = &q;
      M_CDN:   tc = ~|q;
      default: tc = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_universal_reg.sv
// tb/tb_universal_reg.sv - randomized and directed self-checking bench for universal_reg
module tb_universal_reg;

  localparam int W    = 8;
  localparam int RV   = 'hA5;
  localparam int MASK = (1 << W) - 1;

  logic         c = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   m = 3'd0;
  logic [W-1:0] d = '0;
  logic         si = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qp;
  logic         so;
  logic         tc;

  int checks = 0;
  int errors = 0;
  int model_q = 0;
  bit model_valid = 0;

  universal_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut (
    .c  (c),
    .rst(rst),
    .en (en),
    .m  (m),
    .d  (d),
    .si (si),
    .q  (q),
    .qp (qp),
    .so (so),
    .tc (tc)
  );

  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: next register value from the mode table, in plain integer arithmetic
  function automatic int ref_next(input int cur, input bit r, input bit e,
                                  input int mode, input int dv, input bit s);
    if (r) return RV;
    if (!e) return cur;
    case (mode)
      1: return dv;
      2: return (cur >> 1) | (int'(s) << (W - 1));
      3: return ((cur << 1) | int'(s)) & MASK;
      4: return (cur >> 1) | ((cur & 1) << (W - 1));
      5: return ((cur << 1) | (cur >> (W - 1))) & MASK;
      6: return (cur + 1) & MASK;
      7: return (cur - 1) & MASK;
      default: return cur;
    endcase
  endfunction

  function automatic int ref_so(input int cur, input int mode);
    if (mode == 2 || mode == 4) return cur & 1;
    if (mode == 3 || mode == 5) return (cur >> (W - 1)) & 1;
    return 0;
  endfunction

  function automatic int ref_tc(input int cur, input int mode);
    if (mode == 6) return int'(cur == MASK);
    if (mode == 7) return int'(cur == 0);
    return 0;
  endfunction

  // Apply one cycle of inputs, check flags before the edge and state after it
  task automatic step(input bit r, input bit e, input int mode, input int dv, input bit s);
    @(negedge c);
    rst = r;
    en  = e;
    m   = mode[2:0];
    d   = dv[W-1:0];
    si  = s;
    #1;
    if (model_valid) begin
      check("so_pre", {31'b0, so}, ref_so(model_q, mode));
      check("tc_pre", {31'b0, tc}, ref_tc(model_q, mode));
    end
    @(posedge c);
    if (model_valid || r) begin
      model_q = ref_next(model_q, r, e, mode, dv, s);
      model_valid = 1;
    end
    #1;
    if (model_valid) begin
      check("q", {24'b0, q}, model_q);
      check("qp", {24'b0, qp}, (~model_q) & MASK);
    end
  endtask

  initial begin
    // Reset and complement
    step(1, 1, 1, 'hFF, 0);
    check("rst_q", {24'b0, q}, 32'hA5);
    check("rst_qp", {24'b0, qp}, 32'h5A);
    check("rst_so_hold", {31'b0, so}, 32'h0);
    step(1, 1, 1, 'hFF, 0);
    check("rst_over_load", {24'b0, q}, 32'hA5);

    // Load then hold with enable low
    step(0, 1, 1, 'h3C, 0);
    check("load_3c", {24'b0, q}, 32'h3C);
    for (int k = 0; k < 3; k++) step(0, 0, 6, 0, 0);
    check("hold_3c", {24'b0, q}, 32'h3C);
    check("hold_tc", {31'b0, tc}, 32'h0);

    // Shifts
    step(0, 1, 1, 'h81, 0);
    step(0, 1, 2, 0, 0);
    check("shr_40", {24'b0, q}, 32'h40);
    step(0, 1, 3, 0, 1);
    check("shl_81", {24'b0, q}, 32'h81);

    // Rotates
    step(0, 1, 1, 'h01, 0);
    step(0, 1, 4, 0, 1);
    check("ror_80", {24'b0, q}, 32'h80);
    step(0, 1, 5, 0, 0);
    check("rol_01", {24'b0, q}, 32'h01);
    step(0, 1, 5, 0, 0);
    check("rol_02", {24'b0, q}, 32'h02);

    // Count wrap in both directions
    step(0, 1, 1, 'hFE, 0);
    step(0, 1, 6, 0, 0);
    check("cup_ff", {24'b0, q}, 32'hFF);
    check("cup_tc1", {31'b0, tc}, 32'h1);
    step(0, 1, 6, 0, 0);
    check("cup_wrap", {24'b0, q}, 32'h00);
    check("cup_tc0", {31'b0, tc}, 32'h0);
    step(0, 1, 7, 0, 0);
    check("cdn_wrap", {24'b0, q}, 32'hFF);

    // Reset in the middle of counting
    step(0, 1, 1, 'h7F, 0);
    step(1, 1, 6, 0, 0);
    check("mid_rst", {24'b0, q}, 32'hA5);
    step(0, 1, 6, 0, 0);
    check("after_rst_cup", {24'b0, q}, 32'hA6);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
           bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/universal_reg.md
Name: universal_reg

Overview:
- Parametrised WIDTH-bit synchronous register that succeeds the single-bit gated D storage element.
- Adds edge-triggered storage, synchronous reset, clock enable and an 8-way mode select: hold, load, shift, rotate and up/down count.
- Provides true and complement outputs, matching the existing q/qp pair, plus serial-out and terminal-count flags.
- Used as the general-purpose storage/shift/count primitive in lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits.

Ports:
- c  input  1  clock; all state changes occur on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; 0 = hold, regardless of mode.
- m  input  3  mode select; encodings are listed under Behaviour.
- d  input  WIDTH  parallel load data.
- si  input  1  serial in for shift modes.
- q  output  WIDTH  register contents.
- qp  output  WIDTH  bitwise complement of q.
- so  output  1  serial out: bit that leaves on the next shift.
- tc  output  1  terminal count flag.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port is c, reset port is rst.
- Priority on each rising edge of c:
  - rst=1: q<=RESET_VAL.
  - else en=0: q holds.
  - else the action selected by m.
- Reset timing: reset is sampled only at the edge. rst asserted mid-operation (any mode) overrides that edge; the following edge resumes normal operation from RESET_VAL.
- Mode encodings (in shared package):
  - 000 HOLD: q<=q.
  - 001 LOAD: q<=d.
  - 010 SHR: q<={si, q[WIDTH-1:1]}.
  - 011 SHL: q<={q[WIDTH-2:0], si}.
  - 100 ROR: q<={q[0], q[WIDTH-1:1]}.
  - 101 ROL: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 CUP: q<=q+1 modulo 2^WIDTH; all-ones wraps to 0.
  - 111 CDN: q<=q-1 modulo 2^WIDTH; 0 wraps to all-ones.
- Latency: one edge. The new q is visible after the edge; there is no pipelining.
- qp: always exactly ~q, driven from the same state. qp is never independently stored and never equals q in any bit.
- so: combinational from q and m.
  - SHR/ROR: so=q[0].
  - SHL/ROL: so=q[WIDTH-1].
  - All other modes: so=0.
- tc: combinational from q and m; asserted regardless of en, so cascaded stages can gate on en&tc.
  - CUP: tc=1 iff q==all-ones.
  - CDN: tc=1 iff q==0.
  - All other modes: tc=0.
- Mode changes take effect on the edge where the new m is sampled; no settling cycle is needed.
- Reset values: q=RESET_VAL, qp=~RESET_VAL. so and tc follow from q and m (e.g. 0 in HOLD).
- No undefined states: every m encoding is decoded, and the default branch holds.

Decomposition:
- Package universal_reg_pkg:
  - mode localparams M_HOLD..M_CDN (3-bit).
  - width-legality check constant.
- Sub-module dff_cell: one-bit edge-triggered flop with sync reset and enable.
  - Ports: c, rst, en, rv, d, q, qp.
  - universal_reg instantiates WIDTH of these via generate, feeding each cell's d from a per-bit next-state mux.

Test Plan:
- Reset and complement: WIDTH=8, RESET_VAL=8'hA5; rst=1 for 1 edge -> q=8'hA5, qp=8'h5A. rst held with en=1, m=LOAD, d=FF -> q stays A5.
- Load then hold: m=LOAD, d=8'h3C, en=1 -> q=3C next edge. en=0 with m=CUP for 3 edges -> q stays 3C, tc=0.
- Shifts: q=8'h81, m=SHR, si=0 -> q=40, so was 1 before the edge. m=SHL, si=1 from q=40 -> q=81.
- Rotates: q=8'h01, m=ROR -> q=80. m=ROL twice from 80 -> 01 then 02.
- Count wrap: load FE, m=CUP -> FF with tc=1, next edge -> 00 with tc=0. m=CDN from 00 -> tc=1, next edge -> FF.
- Mid-operation reset: counting up at q=7F, assert rst for one edge -> q=A5 (RESET_VAL). Next edge with CUP -> A6.
